// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver/transmitter state encoding and frame width.
package uart_pkg;

    localparam int DATA_BITS = 8;

    typedef enum logic [2:0] {
        SYNC_IDLE,
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the asynchronous serial line; resets to the idle (high) level.
module uart_rx_sync (
    input  logic clk_fpga,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk_fpga) begin
        if (rst) begin
            meta <= 1'b1;
            q    <= 1'b1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with internal clocks-per-bit timing.
// Define UART_RX_PARITY_EN for 8E1 frames with a parity_err output.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLK_DIV   = 434,
    parameter int IDLE_BITS = 10
) (
    input  logic                 clk_fpga,
    input  logic                 rst,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data,
    output logic                 valid,
    output logic                 frame_err,
`ifdef UART_RX_PARITY_EN
    output logic                 parity_err,
`endif
    output logic                 busy
);

    localparam int PH_W        = $clog2(CLK_DIV);
    localparam int IDLE_CYCLES = IDLE_BITS * CLK_DIV;
    localparam int IDLE_W      = $clog2(IDLE_CYCLES + 1);
    localparam int IDX_W       = $clog2(DATA_BITS);

    localparam logic [PH_W-1:0]   PH_LAST   = PH_W'(CLK_DIV - 1);
    localparam logic [PH_W-1:0]   PH_HALF   = PH_W'(CLK_DIV / 2 - 1);
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(IDLE_CYCLES - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(DATA_BITS - 1);

    logic                 rx_s;
    logic                 rx_prev;
    state_t               state;
    logic [PH_W-1:0]      phase;
    logic [IDLE_W-1:0]    idle_cnt;
    logic [IDX_W-1:0]     bit_idx;
    logic [DATA_BITS-1:0] shift;
`ifdef UART_RX_PARITY_EN
    logic                 par_bit;
`endif

    uart_rx_sync u_sync (
        .clk_fpga (clk_fpga),
        .rst      (rst),
        .d        (rx),
        .q        (rx_s)
    );

    // Start is a falling edge, so a line still low after a framing error cannot retrigger.
    always_ff @(posedge clk_fpga) begin
        if (rst) begin
            state     <= SYNC_IDLE;
            phase     <= '0;
            idle_cnt  <= '0;
            bit_idx   <= '0;
            shift     <= '0;
            rx_prev   <= 1'b1;
            data      <= '0;
            valid     <= 1'b0;
            frame_err <= 1'b0;
            busy      <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bit    <= 1'b0;
            parity_err <= 1'b0;
`endif
        end else begin
            valid     <= 1'b0;
            frame_err <= 1'b0;
            rx_prev   <= rx_s;
`ifdef UART_RX_PARITY_EN
            parity_err <= 1'b0;
`endif
            case (state)
                SYNC_IDLE: begin
                    if (!rx_s) begin
                        idle_cnt <= '0;
                    end else if (idle_cnt == IDLE_LAST) begin
                        idle_cnt <= '0;
                        state    <= IDLE;
                    end else begin
                        idle_cnt <= idle_cnt + IDLE_W'(1);
                    end
                end
                IDLE: begin
                    if (rx_prev && !rx_s) begin
                        state   <= START;
                        phase   <= '0;
                        bit_idx <= '0;
                        busy    <= 1'b1;
                    end
                end
                START: begin
                    if (phase == PH_HALF) begin
                        phase <= '0;
                        if (rx_s) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end else begin
                            state <= DATA;
                        end
                    end else begin
                        phase <= phase + PH_W'(1);
                    end
                end
                DATA: begin
                    if (phase == PH_LAST) begin
                        phase          <= '0;
                        shift[bit_idx] <= rx_s;
                        if (bit_idx == IDX_LAST) begin
`ifdef UART_RX_PARITY_EN
                            state <= PARITY;
`else
                            state <= STOP;
`endif
                        end else begin
                            bit_idx <= bit_idx + IDX_W'(1);
                        end
                    end else begin
                        phase <= phase + PH_W'(1);
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (phase == PH_LAST) begin
                        phase   <= '0;
                        par_bit <= rx_s;
                        state   <= STOP;
                    end else begin
                        phase <= phase + PH_W'(1);
                    end
                end
`endif
                // Framing error outranks parity error; only a clean frame updates data.
                STOP: begin
                    if (phase == PH_LAST) begin
                        phase <= '0;
                        state <= IDLE;
                        busy  <= 1'b0;
                        if (!rx_s) begin
                            frame_err <= 1'b1;
`ifdef UART_RX_PARITY_EN
                        end else if ((^shift) != par_bit) begin
                            parity_err <= 1'b1;
`endif
                        end else begin
                            data  <= shift;
                            valid <= 1'b1;
                        end
                    end else begin
                        phase <= phase + PH_W'(1);
                    end
                end
                default: begin
                    state <= SYNC_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx (CLK_DIV=16, IDLE_BITS=2) with an event scoreboard.
module tb_uart_rx;

    localparam int CLK_HALF = 50;
    localparam int BIT_T    = 1600;
    localparam int SLOW_T   = 1648;

    localparam int EV_VALID = 0;
    localparam int EV_FERR  = 1;
    localparam int EV_PERR  = 2;

    typedef struct {
        int         kind;
        logic [7:0] data;
    } event_t;

    logic       clk_fpga = 1'b0;
    logic       rst      = 1'b0;
    logic       rx       = 1'b1;
    logic [7:0] data;
    logic       valid;
    logic       frame_err;
    logic       busy;
    logic       perr;

    event_t     sb[$];
    logic [7:0] last_byte = 8'h00;
    int         n_checks = 0;
    int         n_fail = 0;
    int         busy_cycles = 0;
`ifdef UART_RX_PARITY_EN
    logic       bad_par = 1'b0;
`endif

    uart_rx #(
        .CLK_DIV   (16),
        .IDLE_BITS (2)
    ) dut (
        .clk_fpga   (clk_fpga),
        .rst        (rst),
        .rx         (rx),
        .data       (data),
        .valid      (valid),
        .frame_err  (frame_err),
`ifdef UART_RX_PARITY_EN
        .parity_err (perr),
`endif
        .busy       (busy)
    );

`ifndef UART_RX_PARITY_EN
    assign perr = 1'b0;
`endif

    always #(CLK_HALF) clk_fpga = ~clk_fpga;

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic expect_event(input int kind, input logic [7:0] d);
        event_t e;
        e.kind = kind;
        e.data = d;
        sb.push_back(e);
    endtask

    task automatic apply_reset();
        @(negedge clk_fpga);
        rst = 1'b1;
        repeat (3) @(negedge clk_fpga);
        rst = 1'b0;
        sb.delete();
        last_byte = 8'h00;
    endtask

    task automatic apply_stimulus(input logic [7:0] d, input logic stop_val, input int bit_t);
        rx = 1'b0;
        #(bit_t);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            #(bit_t);
        end
`ifdef UART_RX_PARITY_EN
        rx = (^d) ^ bad_par;
        #(bit_t);
`endif
        rx = stop_val;
        #(bit_t);
        rx = 1'b1;
    endtask

    task automatic wait_drain(input string tag, input int max_cycles);
        int n = 0;
        while (sb.size() != 0 && n < max_cycles) begin
            @(negedge clk_fpga);
            n++;
        end
        check_output(tag, sb.size(), 0);
    endtask

    // Every output pulse must match the oldest pending expectation.
    always @(negedge clk_fpga) begin
        event_t e;
        int     kind;
        if (busy) busy_cycles++;
        if (valid || frame_err || perr) begin
            check_output("pulse_exclusive", 32'(valid) + 32'(frame_err) + 32'(perr), 1);
            check_output("sb_has_entry", 32'(sb.size() > 0), 1);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                kind = valid ? EV_VALID : (frame_err ? EV_FERR : EV_PERR);
                check_output("event_kind", kind, e.kind);
                check_output("event_data", 32'(data), 32'(e.data));
            end
        end
    end

    initial begin
        #(5_000_000);
        $display("[TB] FAIL watchdog: observed timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        apply_reset();
        @(negedge clk_fpga);
        check_output("reset_data", 32'(data), 0);
        check_output("reset_valid", 32'(valid), 0);
        check_output("reset_frame_err", 32'(frame_err), 0);
        check_output("reset_busy", 32'(busy), 0);

        // Clean frame after the idle qualification period.
        repeat (40) @(negedge clk_fpga);
        busy_cycles = 0;
        expect_event(EV_VALID, 8'hA5);
        last_byte = 8'hA5;
        apply_stimulus(8'hA5, 1'b1, BIT_T);
        wait_drain("a5_drain", 60);
        repeat (20) @(negedge clk_fpga);
        check_output("a5_busy_len", 32'(busy_cycles >= 145 && busy_cycles <= 165), 1);
        check_output("a5_busy_low", 32'(busy), 0);

        // A frame before the idle period expires must be ignored.
        apply_reset();
        repeat (5) @(negedge clk_fpga);
        apply_stimulus(8'h00, 1'b1, BIT_T);
        repeat (48) @(negedge clk_fpga);
        check_output("early_no_output", 32'(data), 0);
        expect_event(EV_VALID, 8'h3C);
        last_byte = 8'h3C;
        apply_stimulus(8'h3C, 1'b1, BIT_T);
        wait_drain("3c_drain", 60);

        // Short low glitch rejected by the mid-start-bit sample.
        repeat (20) @(negedge clk_fpga);
        rx = 1'b0;
        repeat (4) @(negedge clk_fpga);
        rx = 1'b1;
        check_output("glitch_busy_high", 32'(busy), 1);
        repeat (20) @(negedge clk_fpga);
        check_output("glitch_busy_low", 32'(busy), 0);
        check_output("glitch_data_kept", 32'(data), 32'(last_byte));

        // Framing error keeps data, then recovery on a good frame.
        expect_event(EV_FERR, last_byte);
        apply_stimulus(8'hFF, 1'b0, BIT_T);
        wait_drain("ferr_drain", 60);
        repeat (40) @(negedge clk_fpga);
        expect_event(EV_VALID, 8'h01);
        last_byte = 8'h01;
        apply_stimulus(8'h01, 1'b1, BIT_T);
        wait_drain("01_drain", 60);

        // Back-to-back frames from a sender running about 3% slow.
        repeat (40) @(negedge clk_fpga);
        expect_event(EV_VALID, 8'h00);
        expect_event(EV_VALID, 8'hFF);
        expect_event(EV_VALID, 8'h55);
        last_byte = 8'h55;
        apply_stimulus(8'h00, 1'b1, SLOW_T);
        apply_stimulus(8'hFF, 1'b1, SLOW_T);
        apply_stimulus(8'h55, 1'b1, SLOW_T);
        wait_drain("b2b_drain", 60);
        check_output("b2b_data", 32'(data), 32'h55);

        // Reset in the middle of data bit 4 aborts the frame.
        repeat (40) @(negedge clk_fpga);
        fork
            apply_stimulus(8'h5A, 1'b1, BIT_T);
            begin
                #(BIT_T * 5 + BIT_T / 2);
                @(negedge clk_fpga);
                check_output("midrst_busy_before", 32'(busy), 1);
                rst = 1'b1;
                @(negedge clk_fpga);
                check_output("midrst_busy_after", 32'(busy), 0);
                check_output("midrst_valid", 32'(valid), 0);
                rst = 1'b0;
                sb.delete();
                last_byte = 8'h00;
            end
        join
        repeat (40) @(negedge clk_fpga);
        check_output("midrst_data_cleared", 32'(data), 0);

`ifdef UART_RX_PARITY_EN
        // Wrong parity suppresses valid; correct parity is accepted.
        bad_par = 1'b1;
        expect_event(EV_PERR, 8'h00);
        apply_stimulus(8'h07, 1'b1, BIT_T);
        bad_par = 1'b0;
        wait_drain("perr_drain", 60);
        repeat (40) @(negedge clk_fpga);
        expect_event(EV_VALID, 8'h07);
        last_byte = 8'h07;
        apply_stimulus(8'h07, 1'b1, BIT_T);
        wait_drain("par_ok_drain", 60);
`endif

        repeat (10) @(negedge clk_fpga);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
